// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage downstream of execute.
//
// Purpose:
//   Non-memory bundles pass to writeback through one register stage.
//   Loads and stores issue one outstanding request on a valid/ready bus,
//   wait for the response, align/extend load data and present exactly one
//   writeback beat per instruction. Misaligned or illegal accesses skip the
//   bus and produce a faulting beat in the next cycle.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_*                 execute bundle (valid/ready handshake)
//   bus_req_*            word-aligned request (valid/ready handshake)
//   bus_rsp_*            response, exactly one per request
//   out_*                writeback beat (valid/ready handshake)
//
// Build option:
//   MEM_ACCESS_STATS_EN  adds saturating 32-bit counters stat_loads,
//                        stat_stores and stat_stall_cycles.
//
// States:
//   state  | meaning
//   IDLE   | can accept a bundle when the output slot is free or draining
//   REQ    | bus request presented, held stable until bus_req_ready
//   WAIT   | request accepted, waiting for bus_rsp_valid
module mem_access #(
  parameter int REG_WIDTH = 32,
  parameter int HART_W    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HART_W-1:0]    in_hart_sel,
  input  logic                 in_mem_rd_en,
  input  logic                 in_mem_wr_en,
  input  logic [3:0]           in_mem_wr_ben,
  input  logic                 in_reg_wr_en,
  input  logic [1:0]           in_reg_wr_size,
  input  logic                 in_reg_wr_sign_ext,
  input  logic [4:0]           in_reg_wr_addr,
  input  logic [REG_WIDTH-1:0] in_lane_j,
  input  logic [REG_WIDTH-1:0] in_lane_k,
  output logic                 bus_req_valid,
  input  logic                 bus_req_ready,
  output logic [REG_WIDTH-1:0] bus_req_addr,
  output logic                 bus_req_we,
  output logic [3:0]           bus_req_ben,
  output logic [REG_WIDTH-1:0] bus_req_wdata,
  input  logic                 bus_rsp_valid,
  input  logic [REG_WIDTH-1:0] bus_rsp_rdata,
  input  logic                 bus_rsp_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [HART_W-1:0]    out_hart_sel,
  output logic                 out_reg_wr_en,
  output logic [4:0]           out_reg_wr_addr,
  output logic [REG_WIDTH-1:0] out_reg_wr_data,
`ifdef MEM_ACCESS_STATS_EN
  output logic [31:0]          stat_loads,
  output logic [31:0]          stat_stores,
  output logic [31:0]          stat_stall_cycles,
`endif
  output logic                 out_fault
);

  if (REG_WIDTH != 32) begin : g_width_check
    $error("mem_access: only REG_WIDTH == 32 is supported");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0] off;
  logic       is_mem;
  logic       accept;
  logic [2:0] acc_bytes;
  logic       misaligned;
  logic       illegal;
  logic       fault_in;
  logic       rsp_done;

  // Context of the in-flight memory instruction.
  logic [HART_W-1:0] req_hart;
  logic              req_is_load;
  logic [1:0]        req_size;
  logic              req_sext;
  logic [1:0]        req_off;
  logic              req_wr_en;
  logic [4:0]        req_wr_addr;

  logic [REG_WIDTH-1:0] rsp_shifted;
  logic [REG_WIDTH-1:0] load_data;

  assign off      = in_lane_k[1:0];
  assign is_mem   = in_mem_rd_en | in_mem_wr_en;
  assign in_ready = ~rst & (state == S_IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign rsp_done = (state == S_WAIT) & bus_rsp_valid;
  assign bus_req_valid = (state == S_REQ);

  // Access size in bytes; 0 marks an illegal size/byte-enable code.
  always_comb begin
    acc_bytes = 3'd0;
    if (in_mem_rd_en) begin
      case (in_reg_wr_size)
        2'd0:    acc_bytes = 3'd1;
        2'd1:    acc_bytes = 3'd2;
        2'd2:    acc_bytes = 3'd4;
        default: acc_bytes = 3'd0;
      endcase
    end else begin
      case (in_mem_wr_ben)
        4'b0001: acc_bytes = 3'd1;
        4'b0011: acc_bytes = 3'd2;
        4'b1111: acc_bytes = 3'd4;
        default: acc_bytes = 3'd0;
      endcase
    end
  end

  assign misaligned = ((acc_bytes == 3'd2) & off[0]) | ((acc_bytes == 3'd4) & (off != 2'd0));
  assign illegal    = (in_mem_rd_en & in_mem_wr_en) | (acc_bytes == 3'd0);
  assign fault_in   = is_mem & (misaligned | illegal);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept & is_mem & ~fault_in) state_nxt = S_REQ;
      S_REQ:   if (bus_req_ready) state_nxt = S_WAIT;
      S_WAIT:  if (bus_rsp_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rsp_shifted = bus_rsp_rdata >> {req_off, 3'b000};

  always_comb begin
    load_data = rsp_shifted;
    case (req_size)
      2'd0:    load_data = {{(REG_WIDTH-8){req_sext & rsp_shifted[7]}}, rsp_shifted[7:0]};
      2'd1:    load_data = {{(REG_WIDTH-16){req_sext & rsp_shifted[15]}}, rsp_shifted[15:0]};
      default: load_data = rsp_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_hart        <= '0;
      req_is_load     <= 1'b0;
      req_size        <= 2'd0;
      req_sext        <= 1'b0;
      req_off         <= 2'd0;
      req_wr_en       <= 1'b0;
      req_wr_addr     <= 5'd0;
      bus_req_addr    <= '0;
      bus_req_we      <= 1'b0;
      bus_req_ben     <= 4'd0;
      bus_req_wdata   <= '0;
      out_valid       <= 1'b0;
      out_hart_sel    <= '0;
      out_reg_wr_en   <= 1'b0;
      out_reg_wr_addr <= 5'd0;
      out_reg_wr_data <= '0;
      out_fault       <= 1'b0;
    end else begin
      if (out_valid & out_ready) out_valid <= 1'b0;

      if (accept & is_mem & ~fault_in) begin
        req_hart      <= in_hart_sel;
        req_is_load   <= in_mem_rd_en;
        req_size      <= in_reg_wr_size;
        req_sext      <= in_reg_wr_sign_ext;
        req_off       <= off;
        req_wr_en     <= in_reg_wr_en;
        req_wr_addr   <= in_reg_wr_addr;
        bus_req_addr  <= {in_lane_k[REG_WIDTH-1:2], 2'b00};
        bus_req_we    <= in_mem_wr_en;
        bus_req_ben   <= in_mem_wr_en ? (in_mem_wr_ben << off) : 4'b1111;
        bus_req_wdata <= in_mem_wr_en ? (in_lane_j << {off, 3'b000}) : '0;
      end

      // Non-memory and faulting bundles complete directly from the accept.
      if (accept & (~is_mem | fault_in)) begin
        out_valid       <= 1'b1;
        out_hart_sel    <= in_hart_sel;
        out_reg_wr_en   <= in_reg_wr_en & ~fault_in;
        out_reg_wr_addr <= in_reg_wr_addr;
        out_reg_wr_data <= fault_in ? '0 : in_lane_k;
        out_fault       <= fault_in;
      end

      // The output slot is guaranteed free here: nothing is accepted in REQ/WAIT.
      if (rsp_done) begin
        out_valid       <= 1'b1;
        out_hart_sel    <= req_hart;
        out_reg_wr_en   <= req_is_load & req_wr_en & ~bus_rsp_err;
        out_reg_wr_addr <= req_wr_addr;
        out_reg_wr_data <= (req_is_load & ~bus_rsp_err) ? load_data : '0;
        out_fault       <= bus_rsp_err;
      end
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads        <= 32'd0;
      stat_stores       <= 32'd0;
      stat_stall_cycles <= 32'd0;
    end else begin
      if (rsp_done & ~bus_rsp_err & req_is_load & (stat_loads != 32'hFFFF_FFFF))
        stat_loads <= stat_loads + 32'd1;
      if (rsp_done & ~bus_rsp_err & ~req_is_load & (stat_stores != 32'hFFFF_FFFF))
        stat_stores <= stat_stores + 32'd1;
      if (in_valid & ~in_ready & (stat_stall_cycles != 32'hFFFF_FFFF))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  in_hart_sel;
  logic        in_mem_rd_en;
  logic        in_mem_wr_en;
  logic [3:0]  in_mem_wr_ben;
  logic        in_reg_wr_en;
  logic [1:0]  in_reg_wr_size;
  logic        in_reg_wr_sign_ext;
  logic [4:0]  in_reg_wr_addr;
  logic [31:0] in_lane_j;
  logic [31:0] in_lane_k;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_we;
  logic [3:0]  bus_req_ben;
  logic [31:0] bus_req_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_hart_sel;
  logic        out_reg_wr_en;
  logic [4:0]  out_reg_wr_addr;
  logic [31:0] out_reg_wr_data;
  logic        out_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access #(.REG_WIDTH(32), .HART_W(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_hart_sel(in_hart_sel),
    .in_mem_rd_en(in_mem_rd_en), .in_mem_wr_en(in_mem_wr_en), .in_mem_wr_ben(in_mem_wr_ben),
    .in_reg_wr_en(in_reg_wr_en), .in_reg_wr_size(in_reg_wr_size),
    .in_reg_wr_sign_ext(in_reg_wr_sign_ext), .in_reg_wr_addr(in_reg_wr_addr),
    .in_lane_j(in_lane_j), .in_lane_k(in_lane_k),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
    .bus_req_we(bus_req_we), .bus_req_ben(bus_req_ben), .bus_req_wdata(bus_req_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_hart_sel(out_hart_sel),
    .out_reg_wr_en(out_reg_wr_en), .out_reg_wr_addr(out_reg_wr_addr),
    .out_reg_wr_data(out_reg_wr_data), .out_fault(out_fault)
  );

  typedef struct {
    logic        hart;
    logic        rd;
    logic        wr;
    logic [3:0]  ben;
    logic        wen;
    logic [1:0]  size;
    logic        sext;
    logic [4:0]  waddr;
    logic [31:0] j;
    logic [31:0] k;
  } bundle_t;

  typedef struct {
    logic        timeout;
    logic        req_seen;
    logic        req_stable;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  ben;
    logic [31:0] wdata;
    logic        beat;
    logic        hart;
    logic        wr_en;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic        fault;
    int          lat;
  } obs_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  ben;
    logic [31:0] wdata;
    logic        fault;
    logic        wr_en;
    logic [31:0] data;
  } exp_t;

  // Reference model: works in bytes and plain integer arithmetic.
  function automatic exp_t model(bundle_t b, logic [31:0] rdata, logic err);
    exp_t   e;
    int     off;
    int     nb;
    logic   mem;
    logic   bad;
    longint mask;
    longint v;
    off  = int'(b.k % 4);
    mem  = b.rd || b.wr;
    nb   = 0;
    if (b.rd) nb = (b.size == 2'd0) ? 1 : (b.size == 2'd1) ? 2 : (b.size == 2'd2) ? 4 : 0;
    else if (b.wr) nb = (b.ben == 4'd1) ? 1 : (b.ben == 4'd3) ? 2 : (b.ben == 4'd15) ? 4 : 0;
    bad = (b.rd && b.wr) || (nb == 0);
    if (!bad && (off % nb) != 0) bad = 1'b1;
    e.fault = mem && bad;
    e.req   = mem && !e.fault;
    e.addr  = b.k - 32'(off);
    e.we    = b.wr;
    e.ben   = b.wr ? 4'(((1 << nb) - 1) << off) : 4'hF;
    e.wdata = 32'(longint'(b.j) << (8 * off));
    e.wr_en = 1'b0;
    e.data  = 32'd0;
    if (!mem) begin
      e.wr_en = b.wen;
      e.data  = b.k;
    end else if (e.req && err) begin
      e.fault = 1'b1;
    end else if (e.req && b.rd) begin
      mask = (64'sd1 <<< (8 * nb)) - 1;
      v    = (longint'(rdata) >> (8 * off)) & mask;
      if (b.sext && v >= (mask + 1) / 2) v = v - (mask + 1);
      e.data  = 32'(v);
      e.wr_en = b.wen;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input bundle_t b);
    in_hart_sel        = b.hart;
    in_mem_rd_en       = b.rd;
    in_mem_wr_en       = b.wr;
    in_mem_wr_ben      = b.ben;
    in_reg_wr_en       = b.wen;
    in_reg_wr_size     = b.size;
    in_reg_wr_sign_ext = b.sext;
    in_reg_wr_addr     = b.waddr;
    in_lane_j          = b.j;
    in_lane_k          = b.k;
  endtask

  function automatic bundle_t blank();
    bundle_t b;
    b = '{hart: 1'b0, rd: 1'b0, wr: 1'b0, ben: 4'd0, wen: 1'b0, size: 2'd0,
          sext: 1'b0, waddr: 5'd0, j: 32'd0, k: 32'd0};
    return b;
  endfunction

  // Drives one bundle through the stage and records what the DUT did.
  task automatic issue(input bundle_t b, input int stall, input int gap,
                       input logic [31:0] rdata, input logic err, output obs_t o);
    int n;
    o = '{timeout: 1'b0, req_seen: 1'b0, req_stable: 1'b0, addr: 32'd0, we: 1'b0,
          ben: 4'd0, wdata: 32'd0, beat: 1'b0, hart: 1'b0, wr_en: 1'b0, waddr: 5'd0,
          data: 32'd0, fault: 1'b0, lat: 0};
    set_bundle(b);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    if (!in_ready) begin
      o.timeout = 1'b1;
      in_valid  = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    in_lane_k = $urandom;
    in_lane_j = $urandom;
    o.lat = 1;
    if (bus_req_valid) begin
      o.req_seen   = 1'b1;
      o.req_stable = 1'b1;
      o.addr  = bus_req_addr;
      o.we    = bus_req_we;
      o.ben   = bus_req_ben;
      o.wdata = bus_req_wdata;
      for (int i = 0; i < stall; i++) begin
        step();
        o.lat++;
        if (!bus_req_valid || bus_req_addr !== o.addr || bus_req_we !== o.we ||
            bus_req_ben !== o.ben || bus_req_wdata !== o.wdata || out_valid)
          o.req_stable = 1'b0;
      end
      bus_req_ready = 1'b1;
      step();
      o.lat++;
      bus_req_ready = 1'b0;
      if (bus_req_valid) o.req_stable = 1'b0;
      for (int i = 0; i < gap; i++) begin
        bus_rsp_rdata = $urandom;
        step();
        o.lat++;
      end
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = rdata;
      bus_rsp_err   = err;
      step();
      o.lat++;
      bus_rsp_valid = 1'b0;
      bus_rsp_err   = 1'b0;
      bus_rsp_rdata = $urandom;
    end
    n = 0;
    while (!out_valid && n < 20) begin step(); o.lat++; n++; end
    if (!out_valid) begin
      o.timeout = 1'b1;
      return;
    end
    o.beat  = 1'b1;
    o.hart  = out_hart_sel;
    o.wr_en = out_reg_wr_en;
    o.waddr = out_reg_wr_addr;
    o.data  = out_reg_wr_data;
    o.fault = out_fault;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus_req_valid); end
    checks++;
    if (out_fault !== 1'b0 || out_reg_wr_en !== 1'b0 || out_reg_wr_data !== 32'd0)
      begin errors++; $display("FAIL reset_payload: got fault=%b wen=%b data=%h want 0", out_fault, out_reg_wr_en, out_reg_wr_data); end
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    bundle_t b;
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      b = blank();
      b.wen = 1'b1;
      b.waddr = 5'(i);
      b.k = 32'(i);
      set_bundle(b);
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_reg_wr_data !== 32'(i) || out_fault !== 1'b0 || out_reg_wr_en !== 1'b1)
        begin errors++; $display("FAIL b2b_beat[%0d]: got v=%b data=%h fault=%b wen=%b want 1/%h/0/1", i, out_valid, out_reg_wr_data, out_fault, out_reg_wr_en, i); end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_signed_byte_load();
    bundle_t b;
    obs_t o;
    out_ready = 1'b1;
    b = blank();
    b.rd = 1'b1; b.size = 2'd0; b.sext = 1'b1; b.wen = 1'b1; b.waddr = 5'd7; b.k = 32'h0000_1003;
    issue(b, 0, 0, 32'h80FF_FFFF, 1'b0, o);
    checks++;
    if (o.timeout !== 1'b0) begin errors++; $display("FAIL sbl_timeout: got %b want 0", o.timeout); end
    checks++;
    if (o.req_seen !== 1'b1 || o.addr !== 32'h0000_1000 || o.we !== 1'b0 || o.ben !== 4'hF)
      begin errors++; $display("FAIL sbl_req: got seen=%b addr=%h we=%b ben=%h want 1/00001000/0/f", o.req_seen, o.addr, o.we, o.ben); end
    checks++;
    if (o.data !== 32'hFFFF_FF80 || o.wr_en !== 1'b1 || o.fault !== 1'b0 || o.waddr !== 5'd7)
      begin errors++; $display("FAIL sbl_beat: got data=%h wen=%b fault=%b wa=%0d want ffffff80/1/0/7", o.data, o.wr_en, o.fault, o.waddr); end
    checks++;
    if (o.lat !== 3) begin errors++; $display("FAIL sbl_latency: got %0d want 3", o.lat); end
  endtask

  task automatic test_half_store();
    bundle_t b;
    obs_t o;
    out_ready = 1'b1;
    b = blank();
    b.wr = 1'b1; b.ben = 4'b0011; b.k = 32'h0000_2002; b.j = 32'h0000_ABCD; b.wen = 1'b1;
    issue(b, 3, 1, 32'h1234_5678, 1'b0, o);
    checks++;
    if (o.req_stable !== 1'b1) begin errors++; $display("FAIL hst_stable: got %b want 1", o.req_stable); end
    checks++;
    if (o.addr !== 32'h0000_2000 || o.we !== 1'b1 || o.ben !== 4'b1100 || o.wdata !== 32'hABCD_0000)
      begin errors++; $display("FAIL hst_req: got addr=%h we=%b ben=%b wdata=%h want 00002000/1/1100/abcd0000", o.addr, o.we, o.ben, o.wdata); end
    checks++;
    if (o.beat !== 1'b1 || o.wr_en !== 1'b0 || o.data !== 32'd0 || o.fault !== 1'b0)
      begin errors++; $display("FAIL hst_beat: got beat=%b wen=%b data=%h fault=%b want 1/0/0/0", o.beat, o.wr_en, o.data, o.fault); end
    checks++;
    if (o.lat !== 7) begin errors++; $display("FAIL hst_latency: got %0d want 7", o.lat); end
  endtask

  task automatic test_misaligned();
    bundle_t b;
    obs_t o;
    out_ready = 1'b1;
    b = blank();
    b.rd = 1'b1; b.size = 2'd2; b.wen = 1'b1; b.k = 32'h0000_3001;
    issue(b, 0, 0, 32'd0, 1'b0, o);
    checks++;
    if (o.req_seen !== 1'b0) begin errors++; $display("FAIL mis_no_req: got req=%b want 0", o.req_seen); end
    checks++;
    if (o.beat !== 1'b1 || o.fault !== 1'b1 || o.wr_en !== 1'b0 || o.lat !== 1)
      begin errors++; $display("FAIL mis_beat: got beat=%b fault=%b wen=%b lat=%0d want 1/1/0/1", o.beat, o.fault, o.wr_en, o.lat); end
  endtask

  task automatic test_bus_error();
    bundle_t b;
    obs_t o;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    b = blank();
    b.rd = 1'b1; b.size = 2'd2; b.wen = 1'b1; b.waddr = 5'd9; b.k = 32'h0000_4000;
    issue(b, 0, 2, 32'hDEAD_BEEF, 1'b1, o);
    checks++;
    if (o.beat !== 1'b1 || o.fault !== 1'b1 || o.wr_en !== 1'b0)
      begin errors++; $display("FAIL err_beat: got beat=%b fault=%b wen=%b want 1/1/0", o.beat, o.fault, o.wr_en); end
    b.k = 32'h0000_0040;
    b.rd = 1'b0;
    set_bundle(b);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_reg_wr_en !== 1'b0 ||
          out_reg_wr_addr !== 5'd9 || out_reg_wr_data !== o.data || in_ready !== 1'b0)
        begin errors++; $display("FAIL err_hold[%0d]: got v=%b f=%b wen=%b wa=%0d rdy=%b want 1/1/0/9/0", i, out_valid, out_fault, out_reg_wr_en, out_reg_wr_addr, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL err_release: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_in_wait();
    bundle_t b;
    out_ready = 1'b1;
    step();
    b = blank();
    b.rd = 1'b1; b.size = 2'd2; b.wen = 1'b1; b.k = 32'h0000_5000;
    set_bundle(b);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (bus_req_valid !== 1'b1) begin errors++; $display("FAIL rw_req: got %b want 1", bus_req_valid); end
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
    rst = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rw_ready_in_rst: got %b want 0", in_ready); end
    step();
    rst = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'h1111_2222;
    step();
    bus_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0 || bus_req_valid !== 1'b0)
        begin errors++; $display("FAIL rw_no_beat[%0d]: got v=%b req=%b want 0/0", i, out_valid, bus_req_valid); end
      step();
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rw_idle: got in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_random();
    bundle_t b;
    obs_t o;
    exp_t e;
    int kind, stall, gap, want_lat;
    logic [31:0] rdata;
    logic err;
    out_ready = 1'b1;
    for (int it = 0; it < 60; it++) begin
      b = blank();
      kind = int'($urandom_range(0, 3));
      b.hart  = 1'($urandom);
      b.waddr = 5'($urandom);
      b.j     = $urandom;
      b.k     = $urandom;
      b.sext  = 1'($urandom);
      b.wen   = 1'($urandom);
      case (kind)
        0: ;
        1: begin b.rd = 1'b1; b.size = 2'($urandom_range(0, 2)); b.wen = 1'b1; end
        2: begin b.wr = 1'b1; b.ben = ($urandom_range(0, 2) == 0) ? 4'b0001 : ($urandom_range(0, 1) == 0) ? 4'b0011 : 4'b1111; end
        default: begin b.rd = 1'($urandom); b.wr = 1'($urandom); b.ben = 4'($urandom); b.size = 2'($urandom); end
      endcase
      if ($urandom_range(0, 1) == 0 && kind != 0) b.k[1:0] = 2'b00;
      stall = int'($urandom_range(0, 2));
      gap   = int'($urandom_range(0, 2));
      rdata = $urandom;
      err   = ($urandom_range(0, 7) == 0);
      e = model(b, rdata, err);
      issue(b, stall, gap, rdata, err, o);
      want_lat = e.req ? (3 + stall + gap) : 1;
      checks++;
      if (o.timeout !== 1'b0 || o.req_seen !== e.req || o.lat !== want_lat)
        begin errors++; $display("FAIL rnd_flow[%0d]: got to=%b req=%b lat=%0d want 0/%b/%0d", it, o.timeout, o.req_seen, o.lat, e.req, want_lat); end
      if (e.req) begin
        checks++;
        if (o.addr !== e.addr || o.we !== e.we || o.ben !== e.ben || (e.we && o.wdata !== e.wdata))
          begin errors++; $display("FAIL rnd_req[%0d]: got a=%h we=%b ben=%h wd=%h want %h/%b/%h/%h", it, o.addr, o.we, o.ben, o.wdata, e.addr, e.we, e.ben, e.wdata); end
      end
      checks++;
      if (o.fault !== e.fault || o.wr_en !== e.wr_en || o.hart !== b.hart || o.waddr !== b.waddr)
        begin errors++; $display("FAIL rnd_beat[%0d]: got f=%b wen=%b h=%b wa=%0d want %b/%b/%b/%0d", it, o.fault, o.wr_en, o.hart, o.waddr, e.fault, e.wr_en, b.hart, b.waddr); end
      if (!e.fault) begin
        checks++;
        if (o.data !== e.data) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", it, o.data, e.data); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    set_bundle(blank());
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = 32'd0;
    bus_rsp_err = 1'b0;
    out_ready = 1'b1;
    #1;
    test_reset();
    test_back_to_back();
    test_signed_byte_load();
    test_half_store();
    test_misaligned();
    test_bus_error();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
